viterbi_traceback: RTL and testbench
====================================

# viterbi_traceback

Frame-based traceback unit for the rate-1/2 Viterbi decoder. It sits downstream of the ACS/path-metric stage and is the consumer of the survivor decisions that stage writes. Per trellis step it buffers one decision bit per state. On frame end it traces back from the supplied best end state and streams the decoded input bits out in original order.

## Interface
- `K`, default 3: constraint length, must be ≥3; `NUM_STATES = 2**(K-1)`.
- `MAX_LEN`, default 16: maximum trellis steps per frame (survivor buffer depth).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `dec_valid`  in  1  decision vector valid.
- `dec_ready`  out  1  block can accept a decision vector.
- `dec_vec`  in  NUM_STATES  bit s = LSB of surviving predecessor of state s.
- `dec_last`  in  1  final trellis step of the frame.
- `end_state`  in  K-1  best final state, sampled with `dec_last`.
- `bit_valid`  out  1  decoded bit valid.
- `bit_ready`  in  1  downstream accepts bit.
- `bit_out`  out  1  decoded input bit.
- `bit_last`  out  1  final decoded bit of frame.
- `busy`  out  1  in TRACE or EMIT.
- `err_len`  out  1  one-cycle pulse: frame truncated at MAX_LEN.

## Operation
- Trellis convention, shared with the encoder: `next_state = {in, state[K-2:1]}`.
- Predecessor of state `cur` is `{cur[K-3:0], dec[t][cur]}`.
- The decoded bit for step t is `cur[K-2]`, taken from the state after step t.
- FSM states:
  - FILL: `dec_ready=1`. Each handshake writes `dec_vec` to `mem[wr_ptr]` and increments `wr_ptr`. On a `dec_last` handshake, latch `end_state` and `len = wr_ptr+1`, then go to TRACE.
  - Truncation: a handshake at `wr_ptr == MAX_LEN-1` without `dec_last` is treated as last. Use `end_state = 0` and pulse `err_len` in the following cycle.
  - TRACE: one step per cycle, `t` from `len-1` down to 0. Set `outbuf[t] = cur[K-2]` and `cur = {cur[K-3:0], mem[t][cur]}`. After `t = 0`, go to EMIT with `rd_ptr = 0`.
  - EMIT: `bit_valid=1`, `bit_out = outbuf[rd_ptr]`, `bit_last = (rd_ptr == len-1)`. On a handshake, increment `rd_ptr`. The handshake with `bit_last` returns to FILL with `wr_ptr = 0`.
- `dec_ready=0` in TRACE and EMIT; input vectors are not accepted until the frame is fully drained.
- `bit_valid` must not drop without a handshake. `bit_out` and `bit_last` stay stable while `bit_valid && !bit_ready`.
- Single-step frame (`dec_last` on the first beat): TRACE lasts 1 cycle, EMIT emits 1 bit with `bit_last=1`.
- Reset mid-TRACE or mid-EMIT abandons the frame. No bits are emitted afterwards. Memory contents are don't-care.

## Timing
- Reset values:
  - state FILL, `wr_ptr=0`, `rd_ptr=0`.
  - `dec_ready=1` (combinational from state).
  - `bit_valid=0`, `bit_out=0`, `bit_last=0`, `busy=0`, `err_len=0`.
- Input throughput: 1 vector per cycle in FILL.
- The `dec_last` handshake at edge E0 is followed by exactly `len` TRACE cycles. `bit_valid` rises at edge E0+len.
- Output throughput: 1 bit per cycle while `bit_ready=1`.
- `dec_ready` returns high in the cycle after the `bit_last` handshake.
- `err_len` is registered and pulses high for exactly the cycle after the truncating handshake.

## Structure
- Package `viterbi_pkg`:
  - `K`, `NUM_STATES`, `MAX_LEN` constants.
  - `state_t` (K-1 bits).
  - `dec_vec_t` (NUM_STATES bits).
  - function `prev_state(cur, dbit)`.
  - The encoder shares the `next_state` definition from this package.
- Sub-module `survivor_mem`: MAX_LEN × NUM_STATES register array with one write port and one combinational read port.
- FSM, pointers and `outbuf` live in the top module.

## Test plan
- Encoder input 1,0,1,1 from state 0, K=3.
  - Stimulus: `dec_vec` bit patterns `0000`, `0000`, `0100`, `0000` (only `dec[2][2]=1`), `end_state=3`, `dec_last` on beat 4.
  - Response: `bit_out` 1,0,1,1, `bit_last` on the 4th bit, `bit_valid` 4 cycles after the last handshake.
- Backpressure: same frame with `bit_ready` toggling 1,0,0,1,…
  - Response: each bit is held stable while stalled; sequence unchanged.
  - `dec_valid` is held high throughout EMIT with `dec_ready=0`; no vector is consumed.
- Frame of exactly MAX_LEN=16 steps, all-zero decisions, `end_state=0`, `dec_last` on beat 16.
  - Response: 16 zeros, `bit_last` on the 16th, `err_len` never asserts.
- 17 beats without `dec_last`.
  - Response: 16th beat forces traceback, `err_len` pulses once, 16 bits emitted.
  - The 17th beat is accepted only after drain, as step 0 of the next frame.
- Single-beat frame, `dec_vec=0000`, `end_state=2`.
  - Response: one bit `1` with `bit_last=1`, 1 cycle after the handshake.
- `rst` asserted on the 2nd EMIT bit.
  - Response: next cycle `bit_valid=0`, `dec_ready=1`, `busy=0`.
  - A following frame decodes correctly.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the rate-1/2 Viterbi decoder: sizes, types
// and the state-transition helpers used by both the encoder and the traceback.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 2 ** (K - 1);
    localparam int MAX_LEN    = 16;

    typedef logic [K-2:0]          state_t;
    typedef logic [NUM_STATES-1:0] dec_vec_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_TRACE,
        ST_EMIT
    } fsm_state_t;

    // New input bit enters at the MSB; the oldest bit falls off the LSB.
    function automatic state_t next_state(input state_t cur, input logic in_bit);
        return {in_bit, cur[K-2:1]};
    endfunction

    function automatic state_t prev_state(input state_t cur, input logic dbit);
        return {cur[K-3:0], dbit};
    endfunction

endpackage

// File: rtl/viterbi_traceback_survivor_mem.sv
// Survivor decision buffer: one decision vector per trellis step, written
// during frame fill and read combinationally during traceback.
module survivor_mem #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    import viterbi_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Frame-based Viterbi traceback: buffers survivor decisions, walks back from
// the supplied best end state, then streams the decoded bits in original order.
module viterbi_traceback #(
    parameter int K       = 3,
    parameter int MAX_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [(1<<(K-1))-1:0]   dec_vec,
    input  logic                    dec_last,
    input  logic [K-2:0]            end_state,
    output logic                    bit_valid,
    input  logic                    bit_ready,
    output logic                    bit_out,
    output logic                    bit_last,
    output logic                    busy,
    output logic                    err_len
);
    import viterbi_pkg::*;

    localparam int SW = K - 1;
    localparam int NS = 1 << (K - 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    fsm_state_t         state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      t_q, t_d;
    logic [LW-1:0]      len_q, len_d;
    logic [SW-1:0]      cur_q, cur_d;
    logic [MAX_LEN-1:0] outbuf_q, outbuf_d;
    logic               err_len_q, err_len_d;

    logic               mem_we;
    logic [NS-1:0]      mem_rdata;
    logic               wr_at_end;
    logic               is_last;

    // Predecessor shifts the state left and refills the LSB from the decision.
    function automatic logic [SW-1:0] trace_pred(input logic [SW-1:0] cur, input logic dbit);
        return {cur[SW-2:0], dbit};
    endfunction

    survivor_mem #(
        .DEPTH  (MAX_LEN),
        .WIDTH  (NS),
        .ADDR_W (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (dec_vec),
        .raddr (t_q),
        .rdata (mem_rdata)
    );

    assign wr_at_end = (wr_ptr_q == AW'(MAX_LEN - 1));
    assign is_last   = (LW'(rd_ptr_q) == (len_q - LW'(1)));

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        t_d       = t_q;
        len_d     = len_q;
        cur_d     = cur_q;
        outbuf_d  = outbuf_q;
        err_len_d = 1'b0;
        mem_we    = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                if (dec_valid) begin
                    mem_we = 1'b1;
                    if (dec_last || wr_at_end) begin
                        // A full buffer without dec_last is closed as a truncated frame.
                        cur_d     = dec_last ? end_state : '0;
                        len_d     = LW'(wr_ptr_q) + LW'(1);
                        t_d       = wr_ptr_q;
                        err_len_d = !dec_last;
                        state_d   = ST_TRACE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            ST_TRACE: begin
                outbuf_d[t_q] = cur_q[SW-1];
                cur_d         = trace_pred(cur_q, mem_rdata[cur_q]);
                if (t_q == '0) begin
                    rd_ptr_d = '0;
                    state_d  = ST_EMIT;
                end else begin
                    t_d = t_q - AW'(1);
                end
            end
            ST_EMIT: begin
                if (bit_ready) begin
                    if (is_last) begin
                        wr_ptr_d = '0;
                        state_d  = ST_FILL;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FILL;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_len_q <= err_len_d;
        end
        t_q      <= t_d;
        len_q    <= len_d;
        cur_q    <= cur_d;
        outbuf_q <= outbuf_d;
    end

    assign dec_ready = (state_q == ST_FILL);
    assign busy      = !dec_ready;
    assign bit_valid = (state_q == ST_EMIT);
    assign bit_out   = bit_valid & outbuf_q[rd_ptr_q];
    assign bit_last  = bit_valid & is_last;
    assign err_len   = err_len_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback: directed frame table, hand-written
// corner sequences, and random frames checked against an encoder-level model.
module tb_viterbi_traceback;

    localparam int KK = 3;
    localparam int NS = 1 << (KK - 1);
    localparam int ML = 16;

    typedef logic [ML-1:0][NS-1:0] frame_t;

    typedef struct {
        int              len;
        frame_t          dec;
        int              es;
        logic [ML-1:0]   bits;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            dec_valid = 1'b0;
    logic            dec_ready;
    logic [NS-1:0]   dec_vec = '0;
    logic            dec_last = 1'b0;
    logic [KK-2:0]   end_state = '0;
    logic            bit_valid;
    logic            bit_ready = 1'b0;
    logic            bit_out;
    logic            bit_last;
    logic            busy;
    logic            err_len;

    int n_cmp    = 0;
    int n_bad    = 0;
    int err_seen = 0;
    int pidx     = 0;

    always #5 clk = ~clk;

    viterbi_traceback #(.K(KK), .MAX_LEN(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_vec   (dec_vec),
        .dec_last  (dec_last),
        .end_state (end_state),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_out   (bit_out),
        .bit_last  (bit_last),
        .busy      (busy),
        .err_len   (err_len)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (err_len) err_seen++;
    endtask

    // Reference traceback straight from the trellis rules, using integer state arithmetic.
    function automatic logic [ML-1:0] ref_trace(input int len, input frame_t dec, input int es);
        int cur;
        logic [ML-1:0] r;
        cur = es;
        r = '0;
        for (int t = len - 1; t >= 0; t--) begin
            r[t] = (cur >= NS / 2);
            cur = ((2 * cur) % NS) + int'(dec[t][cur]);
        end
        return r;
    endfunction

    // Encode a random input sequence and plant the true survivor decisions; other bits random.
    task automatic make_random(input int len, output frame_t dec, output int es, output logic [ML-1:0] bits);
        int s;
        s = 0;
        dec = '0;
        bits = '0;
        for (int t = 0; t < ML; t++) begin
            dec[t] = NS'($urandom);
        end
        for (int t = 0; t < len; t++) begin
            int ns;
            logic b;
            b = 1'($urandom_range(0, 1));
            ns = int'(b) * (NS / 2) + s / 2;
            dec[t][ns] = 1'(s % 2);
            bits[t] = b;
            s = ns;
        end
        es = s;
    endtask

    function automatic bit pick_ready(input int mode);
        bit r;
        pidx++;
        case (mode)
            1:       r = ((pidx % 4) == 1) || ((pidx % 4) == 0);
            2:       r = ($urandom_range(0, 2) != 0);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    task automatic send_beats(input string tag, input int len, input frame_t dec, input int es,
                              input bit use_last, input bit gaps);
        int w;
        err_seen = 0;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                dec_valid = 1'b0;
                step();
            end
            dec_valid = 1'b1;
            dec_vec   = dec[i];
            dec_last  = use_last && (i == len - 1);
            end_state = es[KK-2:0];
            w = 0;
            while (!dec_ready && w < 64) begin
                step();
                w++;
            end
            if (!dec_ready) check({tag, "_ready_timeout"}, 0, 1);
            step();
        end
        dec_valid = 1'b0;
        dec_last  = 1'b0;
        check({tag, "_err_len"}, int'(err_len), use_last ? 0 : 1);
        check({tag, "_busy"}, int'(busy), 1);
    endtask

    task automatic collect(input string tag, input int len, input logic [ML-1:0] exp_bits,
                           input int exp_err, input int bp_mode, input bit hold_valid);
        int cyc;
        int stalls;
        pidx = 0;
        cyc = 0;
        if (hold_valid) dec_valid = 1'b1;
        while (!bit_valid && cyc < 64) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, cyc, len);
        for (int b = 0; b < len; b++) begin
            stalls = 0;
            while (!pick_ready(bp_mode) && stalls < 8) begin
                bit_ready = 1'b0;
                step();
                stalls++;
                check($sformatf("%s_stall_valid%0d", tag, b), int'(bit_valid), 1);
                check($sformatf("%s_stall_bit%0d", tag, b), int'(bit_out), int'(exp_bits[b]));
                check($sformatf("%s_stall_last%0d", tag, b), int'(bit_last), (b == len - 1) ? 1 : 0);
                check($sformatf("%s_stall_noacc%0d", tag, b), int'(dec_ready), 0);
            end
            bit_ready = 1'b1;
            check($sformatf("%s_valid%0d", tag, b), int'(bit_valid), 1);
            check($sformatf("%s_bit%0d", tag, b), int'(bit_out), int'(exp_bits[b]));
            check($sformatf("%s_last%0d", tag, b), int'(bit_last), (b == len - 1) ? 1 : 0);
            check($sformatf("%s_noacc%0d", tag, b), int'(dec_ready), 0);
            if (b == len - 1) dec_valid = 1'b0;
            step();
            bit_ready = 1'b0;
        end
        check({tag, "_drained_valid"}, int'(bit_valid), 0);
        check({tag, "_drained_ready"}, int'(dec_ready), 1);
        check({tag, "_drained_busy"}, int'(busy), 0);
        check({tag, "_err_count"}, err_seen, exp_err);
    endtask

    task automatic run_frame(input string tag, input int len, input frame_t dec, input int es,
                             input logic [ML-1:0] exp_bits, input bit use_last, input int bp_mode,
                             input bit gaps, input bit hold_valid);
        send_beats(tag, len, dec, es, use_last, gaps);
        collect(tag, len, exp_bits, use_last ? 0 : 1, bp_mode, hold_valid);
    endtask

    vec_t tbl[3];

    initial begin
        frame_t        rdec;
        int            res;
        logic [ML-1:0] rbits;
        int            rlen;
        int            cyc;

        tbl[0].len = 4;  tbl[0].dec = '0; tbl[0].dec[2] = 4'b0100; tbl[0].es = 3; tbl[0].bits = 16'b1101;
        tbl[1].len = 16; tbl[1].dec = '0; tbl[1].es = 0; tbl[1].bits = 16'h0000;
        tbl[2].len = 1;  tbl[2].dec = '0; tbl[2].es = 2; tbl[2].bits = 16'h0001;

        rst = 1'b1;
        step();
        step();
        check("rst_dec_ready", int'(dec_ready), 1);
        check("rst_bit_valid", int'(bit_valid), 0);
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_last", int'(bit_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err_len", int'(err_len), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].len, tbl[i].dec, tbl[i].es, tbl[i].bits,
                      1'b1, 0, 1'b0, 1'b0);
        end

        // Backpressure with the input side pushing throughout EMIT.
        run_frame("bp", tbl[0].len, tbl[0].dec, tbl[0].es, tbl[0].bits, 1'b1, 1, 1'b0, 1'b1);

        // 16 beats without dec_last force a truncated traceback from state 0.
        make_random(ML, rdec, res, rbits);
        run_frame("trunc", ML, rdec, 0, ref_trace(ML, rdec, 0), 1'b0, 0, 1'b0, 1'b1);
        // The 17th beat starts the next frame at step 0.
        make_random(2, rdec, res, rbits);
        run_frame("after_trunc", 2, rdec, res, rbits, 1'b1, 0, 1'b0, 1'b0);

        // Reset while the second bit is being presented.
        send_beats("rstemit", tbl[0].len, tbl[0].dec, tbl[0].es, 1'b1, 1'b0);
        cyc = 0;
        while (!bit_valid && cyc < 64) begin
            step();
            cyc++;
        end
        check("rstemit_latency", cyc, tbl[0].len);
        bit_ready = 1'b1;
        check("rstemit_bit0", int'(bit_out), 1);
        step();
        bit_ready = 1'b0;
        check("rstemit_bit1", int'(bit_out), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstemit_valid", int'(bit_valid), 0);
        check("rstemit_ready", int'(dec_ready), 1);
        check("rstemit_busy", int'(busy), 0);
        bit_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("rstemit_quiet%0d", i), int'(bit_valid), 0);
        end
        bit_ready = 1'b0;
        run_frame("post_rst", tbl[0].len, tbl[0].dec, tbl[0].es, tbl[0].bits, 1'b1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            rlen = $urandom_range(1, ML);
            make_random(rlen, rdec, res, rbits);
            run_frame($sformatf("rnd%0d", n), rlen, rdec, res, rbits, 1'b1, 2, 1'b1, n[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
